// File: rtl/full_adder1_pkg.sv
// Shared definitions for the registered ripple-carry adder and its scoreboard.
// Optional signed-overflow output is enabled with FULL_ADDER1_OVF_EN.
package full_adder1_pkg;

    localparam int WIDTH_MAX = 64;

    // Returns {co, s} in bits [width:0]; operand bits above width are ignored.
    function automatic logic [WIDTH_MAX:0] add_ref(
        input logic [WIDTH_MAX-1:0] a,
        input logic [WIDTH_MAX-1:0] b,
        input logic                 ci,
        input int unsigned          width
    );
        logic [WIDTH_MAX-1:0] mask;
        mask = (width >= WIDTH_MAX) ? '1 : ((64'd1 << width) - 64'd1);
        return {1'b0, a & mask} + {1'b0, b & mask} + {{WIDTH_MAX{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/full_adder1_if.sv
// Operand/result bundle of full_adder1; OV exists only with FULL_ADDER1_OVF_EN.
interface full_adder1_if #(
    parameter int WIDTH = 1
);
    import full_adder1_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic [WIDTH-1:0] S;
    logic             CO;
`ifdef FULL_ADDER1_OVF_EN
    logic             OV;

    modport master (output A, B, CI, input S, CO, OV);
    modport slave  (input A, B, CI, output S, CO, OV);
`else
    modport master (output A, B, CI, input S, CO);
    modport slave  (input A, B, CI, output S, CO);
`endif

endinterface

// File: rtl/full_adder1_fa_cell.sv
// Purely combinational one-bit full adder cell, the building block of full_adder1.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder1.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// Define FULL_ADDER1_OVF_EN to add the registered signed-overflow output OV.
module full_adder1
    import full_adder1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    full_adder1_if.slave  bus
);

    logic [WIDTH:0]   c_p0;
    logic [WIDTH-1:0] s_p0;

    assign c_p0[0] = bus.CI;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (c_p0[i]),
            .s  (s_p0[i]),
            .co (c_p0[i+1])
        );
    end

    // ---- stage p0 -> p1: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.S  <= '0;
            bus.CO <= 1'b0;
`ifdef FULL_ADDER1_OVF_EN
            bus.OV <= 1'b0;
`endif
        end else begin
            bus.S  <= s_p0;
            bus.CO <= c_p0[WIDTH];
`ifdef FULL_ADDER1_OVF_EN
            // Carry into and out of the sign bit disagree exactly on signed overflow.
            bus.OV <= c_p0[WIDTH] ^ c_p0[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_full_adder1.sv
// Self-checking bench for full_adder1 at widths 1, 4, 8 and 32 driven side by side.
module tb_full_adder1;
    import full_adder1_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    full_adder1_if #(.WIDTH(1))  bus1  ();
    full_adder1_if #(.WIDTH(4))  bus4  ();
    full_adder1_if #(.WIDTH(8))  bus8  ();
    full_adder1_if #(.WIDTH(32)) bus32 ();

    full_adder1 #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    full_adder1 #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    full_adder1 #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    full_adder1 #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t t1[8];
    vec_t t8[6];
    int   widths[4] = '{1, 4, 8, 32};
    logic [63:0] in_a[4];
    logic [63:0] in_b[4];
    logic        in_ci[4];

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference: integer addition of the operands reduced modulo 2^w.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic ci, input int w);
        longint unsigned m, sum;
        m   = (64'd1 << w) - 64'd1;
        sum = (a & m) + (b & m) + {63'd0, ci};
        return {1'b0, sum};
    endfunction

    // Reference: signed result outside the representable range of w bits.
    function automatic logic ref_ov(input logic [63:0] a, input logic [63:0] b,
                                    input logic ci, input int w);
        longint m, sa, sb, s, lo, hi;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        s  = sa + sb + longint'(ci);
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        return (s > hi) || (s < lo);
    endfunction

    task automatic drive(input int k, input logic [63:0] a, input logic [63:0] b, input logic ci);
        in_a[k] = a; in_b[k] = b; in_ci[k] = ci;
        case (k)
            0: begin bus1.A  = a[0:0];  bus1.B  = b[0:0];  bus1.CI  = ci; end
            1: begin bus4.A  = a[3:0];  bus4.B  = b[3:0];  bus4.CI  = ci; end
            2: begin bus8.A  = a[7:0];  bus8.B  = b[7:0];  bus8.CI  = ci; end
            default: begin bus32.A = a[31:0]; bus32.B = b[31:0]; bus32.CI = ci; end
        endcase
    endtask

    function automatic logic [64:0] got(input int k);
        case (k)
            0: return {63'd0, bus1.CO, bus1.S};
            1: return {60'd0, bus4.CO, bus4.S};
            2: return {56'd0, bus8.CO, bus8.S};
            default: return {32'd0, bus32.CO, bus32.S};
        endcase
    endfunction

`ifdef FULL_ADDER1_OVF_EN
    function automatic logic got_ov(input int k);
        case (k)
            0: return bus1.OV;
            1: return bus4.OV;
            2: return bus8.OV;
            default: return bus32.OV;
        endcase
    endfunction
`endif

    task automatic drive_random_all();
        for (int k = 0; k < 4; k++)
            drive(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_w%0d", tag, widths[k]), got(k),
                ref_sum(in_a[k], in_b[k], in_ci[k], widths[k]));
`ifdef FULL_ADDER1_OVF_EN
            chk($sformatf("%s_ov_w%0d", tag, widths[k]), {64'd0, got_ov(k)},
                {64'd0, ref_ov(in_a[k], in_b[k], in_ci[k], widths[k])});
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_w%0d", tag, widths[k]), got(k), 65'd0);
`ifdef FULL_ADDER1_OVF_EN
            chk($sformatf("%s_ov_w%0d", tag, widths[k]), {64'd0, got_ov(k)}, 65'd0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Width-1 exhaustive table: {a, b, ci, s, co, ov}.
        t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
        t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
        t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
        t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
        t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};
        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        t8[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        t8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        t8[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        t8[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset with nonzero inputs and no clock edge in between.
        for (int k = 0; k < 4; k++) drive(k, '1, '1, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        @(negedge clk) rst = 1'b0;

        // Width-1 exhaustive, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(0, {56'd0, t1[i].a}, {56'd0, t1[i].b}, t1[i].ci);
            @(posedge clk); #1;
            chk($sformatf("w1_vec%0d", i), got(0), {63'd0, t1[i].co, t1[i].s[0]});
`ifdef FULL_ADDER1_OVF_EN
            chk($sformatf("w1_ov%0d", i), {64'd0, got_ov(0)}, {64'd0, t1[i].ov});
`endif
            @(negedge clk);
        end

        // Width-8 boundary vectors, also cross-checking the package helper.
        for (int i = 0; i < 6; i++) begin
            drive(2, {56'd0, t8[i].a}, {56'd0, t8[i].b}, t8[i].ci);
            chk($sformatf("add_ref%0d", i), add_ref({56'd0, t8[i].a}, {56'd0, t8[i].b}, t8[i].ci, 8),
                {56'd0, t8[i].co, t8[i].s});
            @(posedge clk); #1;
            chk($sformatf("w8_vec%0d", i), got(2), {56'd0, t8[i].co, t8[i].s});
`ifdef FULL_ADDER1_OVF_EN
            chk($sformatf("w8_ov%0d", i), {64'd0, got_ov(2)}, {64'd0, t8[i].ov});
`endif
            @(negedge clk);
        end

        // Inputs changing between edges must not reach the outputs early.
        drive(2, 64'hFF, 64'h01, 1'b0);
        @(posedge clk); #1;
        chk("hold_before", got(2), 65'h100);
        @(negedge clk);
        drive(2, 64'h01, 64'h01, 1'b0);
        #1 chk("hold_between", got(2), 65'h100);
        @(posedge clk); #1;
        chk("hold_after", got(2), 65'h002);

        // Mid-stream reset: outputs clear at once and stay clear while held.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive_random_all();
            @(posedge clk); #1;
            check_all("pre_rst");
        end
        @(negedge clk);
        drive_random_all();
        #1 rst = 1'b1;
        #1 check_zero("mid_rst");
        @(posedge clk); #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        drive_random_all();
        @(posedge clk); #1;
        check_all("post_rst");

        // Random regression across all widths.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            drive_random_all();
            @(posedge clk); #1;
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
